// File: rtl/alu_accum_stage.sv
// Accumulator/execute stage fed by the 2:1 operand mux. Applies one of eight
// ops against the internal accumulator and registers result plus flags.
// Shifts run one bit per clock under a two-state FSM; the accumulator is
// exported so it can be fed back into the mux.
module alu_accum_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             done,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [SW-1:0]    cnt_q;
  logic             dir_q;   // 1 = shifting left
  logic             carry_q, ovf_q, zero_q, done_q;

  logic [SW-1:0]    k;
  logic             is_shift;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] alu_acc_d;
  logic             alu_c_d, alu_v_d;
  logic             shl_d;
  logic [WIDTH-1:0] step_acc_d;
  logic             step_c_d;

  assign k        = operand[SW-1:0];
  assign is_shift = (op[2:1] == 2'b11);

  // Single-cycle ALU result and one-bit shift step, both off the current acc
  always_comb begin
    sum_d     = {1'b0, acc_q} + {1'b0, operand};
    diff_d    = acc_q - operand;
    alu_acc_d = operand;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    case (op)
      OP_LOAD: alu_acc_d = operand;
      OP_ADD: begin
        alu_acc_d = sum_d[WIDTH-1:0];
        alu_c_d   = sum_d[WIDTH];
        alu_v_d   = (acc_q[WIDTH-1] == operand[WIDTH-1]) &&
                    (sum_d[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_acc_d = diff_d;
        alu_c_d   = (acc_q < operand);
        alu_v_d   = (acc_q[WIDTH-1] != operand[WIDTH-1]) &&
                    (diff_d[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_AND:  alu_acc_d = acc_q & operand;
      OP_OR:   alu_acc_d = acc_q | operand;
      OP_XOR:  alu_acc_d = acc_q ^ operand;
      default: alu_acc_d = acc_q;
    endcase

    // Direction comes from the op on the accept edge, then from the latched copy
    shl_d      = (state_q == IDLE) ? (op == OP_SHL) : dir_q;
    step_acc_d = shl_d ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};
    step_c_d   = shl_d ? acc_q[WIDTH-1] : acc_q[0];
  end

  // FSM, accumulator, flags and done pulse; reset aborts any shift in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_shift) begin
              ovf_q <= 1'b0;
              dir_q <= (op == OP_SHL);
              if (k == '0) begin
                carry_q <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                acc_q   <= step_acc_d;
                carry_q <= step_c_d;
                zero_q  <= (step_acc_d == '0);
                if (k == SW'(1)) begin
                  done_q <= 1'b1;
                end else begin
                  cnt_q   <= k - 1'b1;
                  state_q <= SHIFT;
                end
              end
            end else begin
              acc_q   <= alu_acc_d;
              carry_q <= alu_c_d;
              ovf_q   <= alu_v_d;
              zero_q  <= (alu_acc_d == '0);
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_q   <= step_acc_d;
          carry_q <= step_c_d;
          zero_q  <= (step_acc_d == '0);
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign acc      = acc_q;
  assign carry    = carry_q;
  assign ovf      = ovf_q;
  assign zero     = zero_q;
  assign done     = done_q;
endmodule

// File: tb/tb_alu_accum_stage.sv
// Directed and randomized checks of alu_accum_stage (WIDTH=8). Expected
// results are queued when an op is driven and compared on each done pulse.
module tb_alu_accum_stage;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, done, carry, ovf, zero;
  logic [2:0]   op;
  logic [W-1:0] operand, acc;

  typedef struct packed {
    logic [W-1:0] acc;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;
  res_t m;   // bench reference model state

  alu_accum_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand(operand), .acc(acc), .done(done),
    .carry(carry), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: shifts done by repeated single-bit moves
  function automatic res_t model(input res_t s, input logic [2:0] o, input logic [W-1:0] d);
    res_t r;
    logic [W:0] t;
    int kk;
    r = s;
    r.c = 1'b0;
    r.v = 1'b0;
    case (o)
      3'd0: r.acc = d;
      3'd1: begin
        t = {1'b0, s.acc} + {1'b0, d};
        r.acc = t[W-1:0];
        r.c = t[W];
        r.v = ($signed(s.acc) + $signed(d) > 127) || ($signed(s.acc) + $signed(d) < -128);
      end
      3'd2: begin
        r.acc = s.acc - d;
        r.c = (s.acc < d);
        r.v = ($signed(s.acc) - $signed(d) > 127) || ($signed(s.acc) - $signed(d) < -128);
      end
      3'd3: r.acc = s.acc & d;
      3'd4: r.acc = s.acc | d;
      3'd5: r.acc = s.acc ^ d;
      default: begin
        kk = int'(d[2:0]);
        for (int i = 0; i < kk; i++) begin
          if (o == 3'd6) begin r.c = r.acc[W-1]; r.acc = r.acc << 1; end
          else           begin r.c = r.acc[0];   r.acc = r.acc >> 1; end
        end
      end
    endcase
    r.z = (r.acc == '0);
    return r;
  endfunction

  // Each done pulse retires the oldest queued expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("done_acc",   {24'd0, acc}, {24'd0, e.acc});
        chk("done_carry", {31'd0, carry}, {31'd0, e.c});
        chk("done_ovf",   {31'd0, ovf}, {31'd0, e.v});
        chk("done_zero",  {31'd0, zero}, {31'd0, e.z});
      end
    end
  end

  // Wait (bounded) for in_ready, push expectation, present op for one accept edge
  task automatic issue(input logic [2:0] o, input logic [W-1:0] d, input res_t e, input bit drop);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    sb.push_back(e);
    op = o; operand = d; in_valid = 1'b1;
    @(posedge clk); #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; operand = '0;
    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc",   {24'd0, acc}, 32'h00);
    chk("rst_zero",  {31'd0, zero}, 32'd1);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    idle(1);

    // T2 LOAD 7F, ADD 01 back-to-back
    issue(3'd0, 8'h7F, '{8'h7F, 1'b0, 1'b0, 1'b0}, 1'b0);
    chk("t2_ready_mid", {31'd0, in_ready}, 32'd1);
    issue(3'd1, 8'h01, '{8'h80, 1'b0, 1'b1, 1'b0}, 1'b1);
    chk("t2_done_b2b", {31'd0, done}, 32'd1);
    idle(2);

    // T3 LOAD 05, SUB 06, ADD 01
    issue(3'd0, 8'h05, '{8'h05, 1'b0, 1'b0, 1'b0}, 1'b0);
    issue(3'd2, 8'h06, '{8'hFF, 1'b1, 1'b0, 1'b0}, 1'b0);
    issue(3'd1, 8'h01, '{8'h00, 1'b1, 1'b0, 1'b1}, 1'b1);
    idle(2);

    // T4 LOAD 81, SHL 3 with in_valid held through the busy cycles
    issue(3'd0, 8'h81, '{8'h81, 1'b0, 1'b0, 1'b0}, 1'b0);
    issue(3'd6, 8'h03, '{8'h08, 1'b0, 1'b0, 1'b0}, 1'b0);
    chk("t4_step1_acc",   {24'd0, acc}, 32'h02);
    chk("t4_step1_carry", {31'd0, carry}, 32'd1);
    chk("t4_busy1",       {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t4_step2_acc", {24'd0, acc}, 32'h04);
    chk("t4_busy2",     {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t4_step3_acc", {24'd0, acc}, 32'h08);
    chk("t4_ready_back", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    idle(2);
    chk("t4_hold_acc", {24'd0, acc}, 32'h08);

    // T5 LOAD 3C, SHR 0, SHR 2
    issue(3'd0, 8'h3C, '{8'h3C, 1'b0, 1'b0, 1'b0}, 1'b0);
    issue(3'd7, 8'h00, '{8'h3C, 1'b0, 1'b0, 1'b0}, 1'b1);
    chk("t5_k0_ready", {31'd0, in_ready}, 32'd1);
    issue(3'd7, 8'hF2, '{8'h0F, 1'b0, 1'b0, 1'b0}, 1'b1);
    idle(3);

    // Bitwise ops
    issue(3'd0, 8'hA5, '{8'hA5, 1'b0, 1'b0, 1'b0}, 1'b0);
    issue(3'd3, 8'h0F, '{8'h05, 1'b0, 1'b0, 1'b0}, 1'b0);
    issue(3'd4, 8'hF0, '{8'hF5, 1'b0, 1'b0, 1'b0}, 1'b0);
    issue(3'd5, 8'hF5, '{8'h00, 1'b0, 1'b0, 1'b1}, 1'b1);
    idle(2);

    // Randomized ops against the reference model
    m = '{8'h00, 1'b0, 1'b0, 1'b1};
    m = model(m, 3'd0, 8'h5A);
    issue(3'd0, 8'h5A, m, 1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] rd;
      ro = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      m = model(m, ro, rd);
      issue(ro, rd, m, 1'b1);
    end
    idle(10);
    chk("sb_drained", sb.size(), 32'd0);

    // T6 reset in the middle of SHL 7
    issue(3'd0, 8'hFF, '{8'hFF, 1'b0, 1'b0, 1'b0}, 1'b0);
    op = 3'd6; operand = 8'h07; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_s1", {24'd0, acc}, 32'hFE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_s3", {24'd0, acc}, 32'hF8);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_acc",   {24'd0, acc}, 32'h00);
    chk("t6_zero",  {31'd0, zero}, 32'd1);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_carry", {31'd0, carry}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("t6_no_done", {31'd0, done}, 32'd0);
    end
    chk("t6_acc_hold", {24'd0, acc}, 32'h00);
    chk("sb_empty_end", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
